spi_slave_avmm: RTL

- SPI target (responder) with an Avalon-MM register slave; the counterpart of the team's SPI master controller, for board-level loopback and for exposing this FPGA as an SPI peripheral.
- Oversamples spi_clk, spi_cs_n and spi_mosi in the avmm_clk domain. Supports all four CPOL/CPHA modes and 1..32-bit words, MSB first.
- A received word is captured into RX_DATA. The word in TX_DATA is shifted out on spi_miso.

---
 rtl/spi_slave_avmm_pkg.sv | 39 +++
 rtl/spi_slave_avmm_in_sync.sv | 33 +++
 rtl/spi_slave_avmm.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_avmm_pkg.sv
// Shared definitions for the SPI target: register map, CONTROL/STATUS bit
// positions, FSM state encoding and the word-mask helper.
`timescale 1ns/1ps
package spi_slave_avmm_pkg;

  localparam logic [2:0] ADDR_CONTROL = 3'd0;
  localparam logic [2:0] ADDR_TX_DATA = 3'd1;
  localparam logic [2:0] ADDR_RX_DATA = 3'd2;
  localparam logic [2:0] ADDR_STATUS  = 3'd3;

  localparam int CTRL_LEN_LSB = 0;
  localparam int CTRL_LEN_W   = 6;
  localparam int CTRL_CPOL    = 8;
  localparam int CTRL_CPHA    = 9;
  localparam int CTRL_ENABLE  = 16;
  localparam int CTRL_IRQ_EN  = 17;

  localparam int STAT_RX_VALID = 0;
  localparam int STAT_OVERRUN  = 1;
  localparam int STAT_BUSY     = 2;
  localparam int STAT_TX_EMPTY = 3;
  localparam int STAT_ABORT    = 4;

  // Encoding is shared with the SPI master controller.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } spi_state_e;

  // Mask of the low N = len_m1+1 bits; lengths beyond 32 keep the full word.
  function automatic logic [31:0] word_mask(input logic [5:0] len_m1);
    logic [31:0] m;
    if (len_m1 >= 6'd31) m = '1;
    else                 m = (32'd1 << (len_m1 + 6'd1)) - 32'd1;
    return m;
  endfunction

endpackage

// File: rtl/spi_slave_avmm_in_sync.sv
// Multi-stage synchronizer for one SPI input, plus one extra flop so that
// single-cycle rise/fall pulses can be produced in the system clock domain.
`timescale 1ns/1ps
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Synchronizer chain followed by the edge-detect history flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_q    = r_sync[SYNC_STAGES-1];
  assign o_rise =  r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule

// File: rtl/spi_slave_avmm.sv
// SPI target with an Avalon-MM register slave. SPI inputs are oversampled in
// avmm_clk; all four CPOL/CPHA modes, 1..32-bit words, MSB first.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a CS fall with enable=1
// ACTIVE | frame selected, sampling/shifting on SCLK edges
// DONE   | word captured, SCLK ignored, waiting for CS to rise
`timescale 1ns/1ps
module spi_slave_avmm
  import spi_slave_avmm_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        avmm_clk,
  input  logic        avmm_reset_n,
  input  logic        avmm_cs,
  input  logic [2:0]  avmm_addr,
  input  logic        avmm_write,
  input  logic [31:0] avmm_writedata,
  input  logic        avmm_read,
  output logic [31:0] avmm_readdata,
  output logic        irq,
  input  logic        spi_clk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe
);

  // Configuration and status registers
  logic [5:0]  r_len_m1;
  logic        r_cpol;
  logic        r_cpha;
  logic        r_enable;
  logic        r_irq_en;
  logic [31:0] r_tx_data;
  logic [31:0] r_rx_data;
  logic        r_rx_valid;
  logic        r_overrun;
  logic        r_abort;
  logic        r_tx_empty;
  logic [31:0] r_readdata;
  logic        r_irq;

  // Per-frame state
  spi_state_e  r_state;
  spi_state_e  w_state_nxt;
  logic [5:0]  r_f_len_m1;
  logic        r_f_cpol;
  logic        r_f_cpha;
  logic [31:0] r_tx_shift;
  logic [31:0] r_rx_shift;
  logic [6:0]  r_bit_cnt;
  logic        r_first_lead;

  logic w_clk_q_unused;
  logic w_clk_rise;
  logic w_clk_fall;
  logic w_cs_q;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_mosi_q;
  logic w_mosi_rise_unused;
  logic w_mosi_fall_unused;

  logic        w_start;
  logic        w_capture;
  logic        w_abort_evt;
  logic [6:0]  w_frame_n;
  logic        w_lead;
  logic        w_trail;
  logic        w_sample;
  logic        w_shift;
  logic [4:0]  w_miso_idx;
  logic        w_wr;
  logic        w_rd;
  logic        w_rd_rx;
  logic        w_wr_stat;
  logic        w_busy;
  logic [31:0] w_control;
  logic [31:0] w_status;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .i_clk  (avmm_clk),
    .i_rst_n(avmm_reset_n),
    .i_d    (spi_clk),
    .o_q    (w_clk_q_unused),
    .o_rise (w_clk_rise),
    .o_fall (w_clk_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .i_clk  (avmm_clk),
    .i_rst_n(avmm_reset_n),
    .i_d    (spi_cs_n),
    .o_q    (w_cs_q),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .i_clk  (avmm_clk),
    .i_rst_n(avmm_reset_n),
    .i_d    (spi_mosi),
    .o_q    (w_mosi_q),
    .o_rise (w_mosi_rise_unused),
    .o_fall (w_mosi_fall_unused)
  );

  assign w_frame_n = {1'b0, r_f_len_m1} + 7'd1;
  assign w_lead    = r_f_cpol ? w_clk_fall : w_clk_rise;
  assign w_trail   = r_f_cpol ? w_clk_rise : w_clk_fall;
  // Samples stop once N bits are in, so a trailing edge that lands before
  // the ACTIVE->DONE step cannot disturb the word.
  assign w_sample  = (r_state == ST_ACTIVE) && (r_bit_cnt < w_frame_n) &&
                     (r_f_cpha ? w_trail : w_lead);
  // With cpha=1 the first bit is already on MISO before the first leading edge.
  assign w_shift   = (r_state == ST_ACTIVE) &&
                     (r_f_cpha ? (w_lead && !r_first_lead) : w_trail);

  assign w_miso_idx  = (r_f_len_m1 > 6'd31) ? 5'd31 : r_f_len_m1[4:0];
  assign spi_miso    = r_tx_shift[w_miso_idx];
  assign w_busy      = (r_state != ST_IDLE);
  assign spi_miso_oe = w_busy & ~w_cs_q;

  assign w_wr      = avmm_cs & avmm_write;
  assign w_rd      = avmm_cs & avmm_read;
  assign w_rd_rx   = w_rd & (avmm_addr == ADDR_RX_DATA);
  assign w_wr_stat = w_wr & (avmm_addr == ADDR_STATUS);

  assign w_control = {14'd0, r_irq_en, r_enable, 6'd0, r_cpha, r_cpol, 2'd0, r_len_m1};
  assign w_status  = {27'd0, r_abort, r_tx_empty, w_busy, r_overrun, r_rx_valid};

  // FSM state register
  always_ff @(posedge avmm_clk or negedge avmm_reset_n) begin
    if (!avmm_reset_n) r_state <= ST_IDLE;
    else               r_state <= w_state_nxt;
  end

  // FSM next state and frame events; a completed word beats a late CS rise
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_capture   = 1'b0;
    w_abort_evt = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_cs_fall && r_enable) begin
          w_start     = 1'b1;
          w_state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (r_bit_cnt == w_frame_n) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (w_cs_rise) begin
          w_abort_evt = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (w_cs_q) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Frame datapath: configuration snapshot, shift registers, bit counter
  always_ff @(posedge avmm_clk or negedge avmm_reset_n) begin
    if (!avmm_reset_n) begin
      r_f_len_m1   <= '0;
      r_f_cpol     <= 1'b0;
      r_f_cpha     <= 1'b0;
      r_tx_shift   <= '0;
      r_rx_shift   <= '0;
      r_bit_cnt    <= '0;
      r_first_lead <= 1'b0;
    end else if (w_start) begin
      r_f_len_m1   <= r_len_m1;
      r_f_cpol     <= r_cpol;
      r_f_cpha     <= r_cpha;
      r_tx_shift   <= r_tx_empty ? 32'd0 : r_tx_data;
      r_rx_shift   <= '0;
      r_bit_cnt    <= '0;
      r_first_lead <= 1'b1;
    end else if (r_state == ST_ACTIVE) begin
      if (w_sample) begin
        r_rx_shift <= {r_rx_shift[30:0], w_mosi_q};
        r_bit_cnt  <= r_bit_cnt + 7'd1;
      end
      if (w_shift) r_tx_shift   <= {r_tx_shift[30:0], 1'b0};
      if (w_lead)  r_first_lead <= 1'b0;
    end
  end

  // Register file writes and status bits; sets win over clears
  always_ff @(posedge avmm_clk or negedge avmm_reset_n) begin
    if (!avmm_reset_n) begin
      r_len_m1   <= '0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_enable   <= 1'b0;
      r_irq_en   <= 1'b0;
      r_tx_data  <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_abort    <= 1'b0;
      r_tx_empty <= 1'b1;
    end else begin
      if (w_wr && avmm_addr == ADDR_CONTROL) begin
        r_len_m1 <= avmm_writedata[CTRL_LEN_LSB +: CTRL_LEN_W];
        r_cpol   <= avmm_writedata[CTRL_CPOL];
        r_cpha   <= avmm_writedata[CTRL_CPHA];
        r_enable <= avmm_writedata[CTRL_ENABLE];
        r_irq_en <= avmm_writedata[CTRL_IRQ_EN];
      end
      if (w_wr && avmm_addr == ADDR_TX_DATA) r_tx_data <= avmm_writedata;

      // A TX write in the load cycle belongs to the next frame
      if (w_wr && avmm_addr == ADDR_TX_DATA) r_tx_empty <= 1'b0;
      else if (w_start)                      r_tx_empty <= 1'b1;

      if (w_capture) r_rx_data <= r_rx_shift & word_mask(r_f_len_m1);

      if (w_capture)    r_rx_valid <= 1'b1;
      else if (w_rd_rx) r_rx_valid <= 1'b0;

      // A read racing the capture drains the old word, so it is not an overrun
      if (w_capture && r_rx_valid && !w_rd_rx)            r_overrun <= 1'b1;
      else if (w_wr_stat && avmm_writedata[STAT_OVERRUN]) r_overrun <= 1'b0;

      if (w_abort_evt)                                 r_abort <= 1'b1;
      else if (w_wr_stat && avmm_writedata[STAT_ABORT]) r_abort <= 1'b0;
    end
  end

  // Registered read data and level interrupt
  always_ff @(posedge avmm_clk or negedge avmm_reset_n) begin
    if (!avmm_reset_n) begin
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_rd) begin
        unique case (avmm_addr)
          ADDR_CONTROL: r_readdata <= w_control;
          ADDR_RX_DATA: r_readdata <= r_rx_data;
          ADDR_STATUS:  r_readdata <= w_status;
          default:      r_readdata <= '0;
        endcase
      end
      r_irq <= r_irq_en & (r_rx_valid | r_overrun | r_abort);
    end
  end

  assign avmm_readdata = r_readdata;
  assign irq           = r_irq;

endmodule
